// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle requester for a radix-2 DIT FFT. It walks the stage/group/butterfly loops and issues one
// ROM address per butterfly, then streams the fixed-latency ROM responses out through a credit-protected FIFO.
module fft_twiddle_addr_gen #(
    parameter int MAX_FFT_LENGTH_LOG2 = 12,
    parameter int TWIDDLE_WIDTH       = 16,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic [3:0]                 fft_length_log2_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [15:0]                rom_addr_o,
    output logic                       rom_addr_valid_o,
    input  logic [2*TWIDDLE_WIDTH-1:0] rom_data_i,
    input  logic                       rom_data_valid_i,
    output logic [2*TWIDDLE_WIDTH-1:0] tw_data_o,
    output logic [3:0]                 tw_stage_o,
    output logic                       tw_last_o,
    output logic                       tw_valid_o,
    input  logic                       tw_ready_i
);
    // state    | meaning
    // ST_IDLE  | waiting for a start with a legal length
    // ST_RUN   | issuing ROM requests as FIFO credit allows
    // ST_DRAIN | all requests issued, waiting for the last beat to be accepted
    // ST_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam int MAX = MAX_FFT_LENGTH_LOG2;
    localparam int DW  = 2*TWIDDLE_WIDTH;
    localparam int EW  = DW + 5;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 2;
    localparam logic [MAX-1:0] ONE = {{(MAX-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_len, r_s;
    logic [MAX-1:0]   r_j, r_g;
    logic [3:0]       w_len, w_cur_s;
    logic [MAX-1:0]   w_cur_j, w_cur_g, w_j_max, w_g_max;
    logic [15:0]      w_addr;
    logic             w_len_ok, w_start_ok, w_credit, w_issue, w_last, w_push, w_pop;

    logic             r_addr_valid, r_tag_last, r_infl, r_infl_last, r_err;
    logic [15:0]      r_addr;
    logic [3:0]       r_tag_s, r_infl_s;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic [EW-1:0]    w_head;

    assign w_len_ok   = (fft_length_log2_i != 4'd0) && (fft_length_log2_i <= 4'(MAX));
    assign w_start_ok = (r_state == ST_IDLE) && start_i && w_len_ok;

    // In IDLE the loop position is forced to the origin so the first address leaves on the start edge.
    assign w_len   = (r_state == ST_IDLE) ? fft_length_log2_i : r_len;
    assign w_cur_s = (r_state == ST_IDLE) ? 4'd0 : r_s;
    assign w_cur_j = (r_state == ST_IDLE) ? '0 : r_j;
    assign w_cur_g = (r_state == ST_IDLE) ? '0 : r_g;

    assign w_j_max = (ONE << w_cur_s) - ONE;
    assign w_g_max = (ONE << (w_len - 4'd1 - w_cur_s)) - ONE;
    assign w_last  = (w_cur_s == w_len - 4'd1) && (w_cur_j == w_j_max);
    assign w_addr  = 16'(w_cur_j) << (4'(MAX - 1) - w_cur_s);

    // Reserve a slot for every response that can still land: the one arriving now and the one requested now.
    assign w_credit = (CW'(r_count) + CW'(r_infl) + CW'(r_addr_valid)) < CW'(FIFO_DEPTH);
    assign w_issue  = w_start_ok || ((r_state == ST_RUN) && w_credit);
    assign w_push   = rom_data_valid_i && r_infl;
    assign w_pop    = tw_valid_o && tw_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = w_last ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (w_issue && w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (w_pop && tw_last_o) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_len        <= '0;
            r_s          <= '0;
            r_j          <= '0;
            r_g          <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_tag_s      <= '0;
            r_tag_last   <= 1'b0;
            r_infl       <= 1'b0;
            r_infl_s     <= '0;
            r_infl_last  <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_start_ok) r_len <= fft_length_log2_i;
            if (w_issue) begin
                r_addr     <= w_addr;
                r_tag_s    <= w_cur_s;
                r_tag_last <= w_last;
                if (w_cur_j == w_j_max) begin
                    r_j <= '0;
                    if (w_cur_g == w_g_max) begin
                        r_g <= '0;
                        r_s <= w_cur_s + 4'd1;
                    end else begin
                        r_g <= w_cur_g + ONE;
                        r_s <= w_cur_s;
                    end
                end else begin
                    r_j <= w_cur_j + ONE;
                    r_g <= w_cur_g;
                    r_s <= w_cur_s;
                end
            end
            r_addr_valid <= w_issue;
            r_infl       <= r_addr_valid;
            r_infl_s     <= r_tag_s;
            r_infl_last  <= r_tag_last;

            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_start_ok)
                r_err <= 1'b0;
            else if ((r_state == ST_IDLE) && start_i)
                r_err <= 1'b1;
            if (rom_data_valid_i && !r_infl) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= {r_infl_last, r_infl_s, rom_data_i};
    end

    assign w_head           = r_mem[r_rd];
    assign tw_valid_o       = (r_count != '0);
    assign tw_data_o        = tw_valid_o ? w_head[DW-1:0] : '0;
    assign tw_stage_o       = tw_valid_o ? w_head[DW+3:DW] : 4'd0;
    assign tw_last_o        = tw_valid_o ? w_head[DW+4] : 1'b0;
    assign rom_addr_o       = r_addr;
    assign rom_addr_valid_o = r_addr_valid;
    assign err_o            = r_err;
endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for fft_twiddle_addr_gen: a 1-cycle ROM model tags each response with a sequence
// number so ordering and loss are visible; expected addresses come from the FFT loop formula.
module tb_fft_twiddle_addr_gen;
    localparam int MAXL  = 12;
    localparam int TW    = 16;
    localparam int DEPTH = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i, start_i, tw_ready_i, inj;
    logic [3:0]        fft_length_log2_i;
    logic              busy_o, done_o, err_o, rom_addr_valid_o, rom_data_valid_i;
    logic [15:0]       rom_addr_o;
    logic [2*TW-1:0]   rom_data_i, tw_data_o;
    logic [3:0]        tw_stage_o;
    logic              tw_last_o, tw_valid_o;

    always #5 clk_i = ~clk_i;

    fft_twiddle_addr_gen #(.MAX_FFT_LENGTH_LOG2(MAXL), .TWIDDLE_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .fft_length_log2_i(fft_length_log2_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rom_addr_o(rom_addr_o),
        .rom_addr_valid_o(rom_addr_valid_o), .rom_data_i(rom_data_i), .rom_data_valid_i(rom_data_valid_i),
        .tw_data_o(tw_data_o), .tw_stage_o(tw_stage_o), .tw_last_o(tw_last_o),
        .tw_valid_o(tw_valid_o), .tw_ready_i(tw_ready_i)
    );

    // ROM model: data = {address, response sequence number}, one cycle after the request
    logic        rom_rv;
    logic [31:0] rom_rd;
    logic [15:0] rom_seq = 16'd0;
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rom_rv <= 1'b0;
            rom_rd <= '0;
        end else begin
            rom_rv <= rom_addr_valid_o;
            rom_rd <= {rom_addr_o, rom_seq};
            if (rom_addr_valid_o) rom_seq <= rom_seq + 16'd1;
        end
    end
    assign rom_data_valid_i = rom_rv | inj;
    assign rom_data_i       = rom_rd;

    int          m_cyc = 0, m_out = 0, m_ovf = 0;
    int          m_start = -1, m_first_av = -1, m_first_tv = -1, m_last_hs = -1;
    logic [15:0] m_base;
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_stage[$];
    logic        q_last[$];

    always @(negedge clk_i) begin
        m_cyc++;
        if (start_i && !busy_o && m_start < 0) begin
            m_start = m_cyc;
            m_base  = rom_seq;
        end
        if (rom_addr_valid_o) begin
            q_addr.push_back(rom_addr_o);
            m_out++;
            if (m_first_av < 0) m_first_av = m_cyc;
        end
        if (tw_valid_o && m_first_tv < 0) m_first_tv = m_cyc;
        if (tw_valid_o && tw_ready_i) begin
            q_data.push_back(tw_data_o);
            q_stage.push_back(tw_stage_o);
            q_last.push_back(tw_last_o);
            m_out--;
            if (tw_last_o) m_last_hs = m_cyc;
        end
        if (m_out > DEPTH) m_ovf++;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] qa(input int k);
        return (k < q_addr.size()) ? q_addr[k] : 16'hxxxx;
    endfunction

    function automatic logic [3:0] qs(input int k);
        return (k < q_stage.size()) ? q_stage[k] : 4'hx;
    endfunction

    task automatic arm();
        q_addr.delete(); q_data.delete(); q_stage.delete(); q_last.delete();
        m_start = -1; m_first_av = -1; m_first_tv = -1; m_last_hs = -1; m_out = 0; m_ovf = 0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 20 cycles then high
    task automatic run(input int L, input int mode, input int budget);
        bit ok;
        arm();
        @(posedge clk_i); #1;
        tw_ready_i = (mode != 2);
        start_i = 1'b1;
        fft_length_log2_i = 4'(L);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            case (mode)
                1: tw_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (i == 20) begin
                        check("stall request count", q_addr.size(), 4);
                        check("stall addr valid", rom_addr_valid_o, 0);
                    end
                    tw_ready_i = (i >= 20);
                end
                default: tw_ready_i = 1'b1;
            endcase
        end
        #1;
        check("done reached", ok, 1);
    endtask

    task automatic verify(input int L, input string nm);
        logic [15:0] ea[$];
        logic [3:0]  es[$];
        int nbad_a = 0, nbad_d = 0, nbad_s = 0, nbad_l = 0, total;
        for (int s = 0; s < L; s++)
            for (int g = 0; g < (1 << (L - 1 - s)); g++)
                for (int j = 0; j < (1 << s); j++) begin
                    ea.push_back(16'(j << (MAXL - 1 - s)));
                    es.push_back(4'(s));
                end
        total = ea.size();
        check({nm, " requests"}, q_addr.size(), total);
        check({nm, " beats"}, q_data.size(), total);
        for (int k = 0; k < total; k++) begin
            if (qa(k) !== ea[k]) nbad_a++;
            if (k >= q_data.size()) nbad_d++;
            else begin
                if (q_data[k] !== {ea[k], m_base + 16'(k)}) nbad_d++;
                if (q_stage[k] !== es[k]) nbad_s++;
                if (q_last[k] !== (k == total - 1)) nbad_l++;
            end
        end
        check({nm, " bad addrs"}, nbad_a, 0);
        check({nm, " bad data"}, nbad_d, 0);
        check({nm, " bad stages"}, nbad_s, 0);
        check({nm, " bad last"}, nbad_l, 0);
        check({nm, " fifo overflow"}, m_ovf, 0);
        check({nm, " addr latency"}, m_first_av - m_start, 1);
        check({nm, " tw_valid latency"}, m_first_tv - m_start, 3);
        check({nm, " done after last"}, m_cyc - m_last_hs, 1);
        check({nm, " busy with done"}, busy_o, 1);
        @(negedge clk_i); #1;
        check({nm, " done pulse width"}, done_o, 0);
        check({nm, " busy after done"}, busy_o, 0);
    endtask

    task automatic pulse_start(input logic [3:0] L);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        fft_length_log2_i = L;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
    endtask

    logic [15:0] l2_addr [4]  = '{16'd0, 16'd0, 16'd0, 16'd1024};
    logic [3:0]  l2_stage [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
    logic [15:0] l3_addr [12] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1024, 16'd0, 16'd1024,
                                  16'd0, 16'd512, 16'd1024, 16'd1536};

    initial begin
        reset_n_i = 1'b0; start_i = 1'b0; fft_length_log2_i = 4'd0; tw_ready_i = 1'b0; inj = 1'b0;
        #1;
        check("reset outputs", {busy_o, done_o, err_o, rom_addr_valid_o, tw_valid_o, tw_last_o,
                                tw_stage_o, rom_addr_o, tw_data_o}, 0);
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        run(2, 0, 200);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("L2 addr%0d", k), qa(k), l2_addr[k]);
            check($sformatf("L2 stage%0d", k), qs(k), l2_stage[k]);
        end
        verify(2, "L2");

        run(3, 0, 200);
        for (int k = 0; k < 12; k++) check($sformatf("L3 addr%0d", k), qa(k), l3_addr[k]);
        verify(3, "L3");

        run(3, 2, 300);
        verify(3, "L3 stall");

        pulse_start(4'd0);
        check("L0 err", err_o, 1);
        check("L0 stays idle", {busy_o, rom_addr_valid_o}, 0);
        pulse_start(4'd13);
        check("L13 err", err_o, 1);
        check("L13 stays idle", {busy_o, rom_addr_valid_o}, 0);
        run(1, 0, 50);
        check("err cleared by start", err_o, 0);
        verify(1, "L1");

        @(posedge clk_i); #1 inj = 1'b1;
        @(posedge clk_i); #1 inj = 1'b0;
        @(negedge clk_i);
        check("unsolicited err", err_o, 1);
        check("unsolicited dropped", tw_valid_o, 0);

        @(posedge clk_i); #1;
        tw_ready_i = 1'b1; start_i = 1'b1; fft_length_log2_i = 4'd4;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        check("midrun reset outputs", {busy_o, done_o, err_o, rom_addr_valid_o, tw_valid_o, tw_last_o,
                                       tw_stage_o, rom_addr_o, tw_data_o}, 0);
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        run(4, 0, 200);
        check("L4 first addr", qa(0), 0);
        verify(4, "L4 after reset");

        run(12, 1, 60000);
        verify(12, "L12 random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
